fb_slave_rx_fifo: RTL and testbench
===================================

Name: fb_slave_rx_fifo

Overview:
- Receive-side byte buffer directly downstream of the FreeDM bus slave MAC.
- Captures the slave-segment byte stream from the MAC (RxData/RxValid) into a circular buffer and tags each frame's last byte.
- A frame becomes visible to the local reader only after it ends with a good CRC. Frames that fail CRC, overflow or are aborted are rolled back and counted.
- Local controller drains bytes over a valid/ready interface.

Parameters:
ADDR_W, 8, buffer address width; depth = 2**ADDR_W entries of 9 bits (8 data + last flag)
CNT_W, 8, width of saturating DropCnt

Ports:
MRxClk  input  1  receive clock; the only clock
Reset_n  input  1  asynchronous active-low reset
RxData  input  8  byte from MAC
RxValid  input  1  RxData valid, single-cycle per byte
FrameStart  input  1  one-cycle pulse, MAC entered slave data segment
FrameEnd  input  1  one-cycle pulse, MAC finished slave CRC check
CrcError  input  1  CRC result, sampled only when FrameEnd=1
RdData  output  8  buffered byte to reader
RdValid  output  1  RdData valid
RdReady  input  1  reader accepts RdData when RdValid&RdReady
RdLast  output  1  RdData is last byte of its frame
FrmCnt  output  ADDR_W  committed, not-yet-fully-read frames
DropCnt  output  CNT_W  discarded frames, saturates at all-ones
Overflow  output  1  one-cycle pulse when a frame is dropped for lack of space

Behaviour:
- Reset (Reset_n=0, async): all pointers 0, write FSM W_IDLE, hold register empty, RdData=0, RdValid=0, RdLast=0, FrmCnt=0, DropCnt=0, Overflow=0.
- Pointers:
  - wr_ptr: speculative write pointer.
  - cm_ptr: commit pointer.
  - rd_ptr: read pointer.
  - All are ADDR_W bits and wrap modulo depth.
- Full when wr_ptr+1==rd_ptr; one slot is always unused.
- Write FSM states: W_IDLE, W_RECV, W_DROP.
  - W_IDLE: FrameStart -> W_RECV, hold register cleared. RxValid and FrameEnd are ignored.
  - W_RECV, RxValid and hold register empty: byte goes into the hold register.
  - W_RECV, RxValid and hold register full: held byte is written at wr_ptr with last=0, wr_ptr++, new byte is held. If full at that write, nothing is written and the FSM goes to W_DROP.
  - W_RECV, FrameEnd & ~CrcError & hold register full & not full: held byte is written with last=1, cm_ptr <= wr_ptr+1, wr_ptr++, FrmCnt+1, -> W_IDLE.
  - W_RECV, FrameEnd & CrcError: wr_ptr <= cm_ptr, DropCnt+1, -> W_IDLE.
  - W_RECV, FrameEnd with hold register empty (zero-byte frame): no write, no count, -> W_IDLE.
  - W_RECV, FrameEnd good but full: treated as overflow; rollback, DropCnt+1, Overflow pulse, -> W_IDLE.
  - W_RECV, FrameStart: aborts the current frame; wr_ptr <= cm_ptr, DropCnt+1, stays W_RECV, hold register cleared.
  - W_DROP: Overflow pulses on entry; wr_ptr <= cm_ptr. RxValid is ignored. FrameEnd -> W_IDLE with DropCnt+1, regardless of CrcError. FrameStart -> W_RECV with DropCnt+1.
- Simultaneous events:
  - RxValid with FrameEnd in the same cycle: the incoming byte is the frame's last byte. The held byte (if any) is written with last=0, the incoming byte with last=1. This takes two writes, so the incoming byte is staged and written the next cycle. cm_ptr updates after the last write. FrmCnt increments on the same cycle cm_ptr moves.
  - FrameStart with FrameEnd: FrameEnd is processed first, then FrameStart.
- Read side:
  - The output register loads mem[rd_ptr] (data, last) and rd_ptr++ when (~RdValid | RdReady) and rd_ptr!=cm_ptr.
  - When the register is not loaded and RdReady&RdValid, RdValid falls to 0.
  - Latency from a commit to RdValid is 1 cycle.
  - Sustained throughput is 1 byte/cycle.
  - Uncommitted bytes are never presented.
- FrmCnt: +1 on commit, -1 on RdValid&RdReady&RdLast; both in the same cycle -> unchanged.
- DropCnt saturates and never wraps.
- Reset mid-frame discards everything, including committed data.

Test Plan:
- Good frame 0x11,0x22,0x33 with CrcError=0 -> one cycle after FrameEnd RdValid=1. With RdReady=1 the reader sees 0x11,0x22,0x33 on consecutive cycles, RdLast only on 0x33. FrmCnt goes 0->1->0.
- Frame of 4 bytes with CrcError=1, then good 2-byte frame 0xA5,0x5A -> reader sees only 0xA5,0x5A, DropCnt=1.
- ADDR_W=4, RdReady=0, 20-byte frame -> Overflow pulses once, DropCnt=1, no RdValid. A following 3-byte good frame is still accepted and read correctly.
- FrameStart mid-frame after 2 bytes, then 1 byte 0x7E and good FrameEnd -> DropCnt=1, reader sees single byte 0x7E with RdLast=1.
- Last byte 0x99 coincident with FrameEnd -> 0x99 is delivered with RdLast=1.
- Back-to-back: commit while the reader pops the last byte of the previous frame -> FrmCnt unchanged.
- Reset_n asserted mid-read -> all outputs 0 immediately.

Source files
------------

// File: rtl/fb_slave_rx_fifo.sv
// Receive-side frame buffer behind the FreeDM slave MAC: frames are written
// speculatively and exposed to the reader only once their CRC is known good.
module fb_slave_rx_fifo #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              MRxClk,
    input  logic              Reset_n,
    input  logic [7:0]        RxData,
    input  logic              RxValid,
    input  logic              FrameStart,
    input  logic              FrameEnd,
    input  logic              CrcError,
    output logic [7:0]        RdData,
    output logic              RdValid,
    input  logic              RdReady,
    output logic              RdLast,
    output logic [ADDR_W-1:0] FrmCnt,
    output logic [CNT_W-1:0]  DropCnt,
    output logic              Overflow
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} wState_t;

    wState_t           state, stateNext;
    logic [ADDR_W-1:0] wrPtr, cmPtr, rdPtr;
    logic [ADDR_W-1:0] wrPtrNext, cmPtrNext, wrPtrInc;
    logic              holdValid, holdValidNext;
    logic [7:0]        holdData, holdDataNext;
    logic              lastPend, lastPendNext;
    logic              restart, restartNext;
    logic              full;
    logic              memWe;
    logic [8:0]        memWdata;
    logic [8:0]        mem [DEPTH];
    logic [8:0]        memRd;
    logic              commit, dropInc, ovfNext;
    logic              rdLoad, frmDec;

    assign wrPtrInc = wrPtr + 1'b1;
    assign full     = (wrPtrInc == rdPtr);
    assign memRd    = mem[rdPtr];
    assign rdLoad   = (~RdValid | RdReady) & (rdPtr != cmPtr);
    assign frmDec   = RdValid & RdReady & RdLast;

    always_comb begin
        stateNext     = state;
        wrPtrNext     = wrPtr;
        cmPtrNext     = cmPtr;
        holdValidNext = holdValid;
        holdDataNext  = holdData;
        lastPendNext  = 1'b0;
        restartNext   = 1'b0;
        memWe         = 1'b0;
        memWdata      = '0;
        commit        = 1'b0;
        dropInc       = 1'b0;
        ovfNext       = 1'b0;
        unique case (state)
            W_IDLE: begin
                if (FrameStart) begin
                    stateNext     = W_RECV;
                    holdValidNext = 1'b0;
                end
            end
            W_RECV: begin
                if (lastPend) begin
                    // Second write of a byte that arrived together with FrameEnd.
                    holdValidNext = 1'b0;
                    stateNext     = (restart | FrameStart) ? W_RECV : W_IDLE;
                    if (full) begin
                        wrPtrNext = cmPtr;
                        dropInc   = 1'b1;
                        ovfNext   = 1'b1;
                    end else begin
                        memWe     = 1'b1;
                        memWdata  = {1'b1, holdData};
                        wrPtrNext = wrPtrInc;
                        cmPtrNext = wrPtrInc;
                        commit    = 1'b1;
                    end
                end else if (FrameEnd) begin
                    holdValidNext = 1'b0;
                    stateNext     = FrameStart ? W_RECV : W_IDLE;
                    if (CrcError) begin
                        wrPtrNext = cmPtr;
                        dropInc   = 1'b1;
                    end else if (RxValid) begin
                        if (holdValid && full) begin
                            wrPtrNext = cmPtr;
                            dropInc   = 1'b1;
                            ovfNext   = 1'b1;
                        end else begin
                            if (holdValid) begin
                                memWe     = 1'b1;
                                memWdata  = {1'b0, holdData};
                                wrPtrNext = wrPtrInc;
                            end
                            holdValidNext = 1'b1;
                            holdDataNext  = RxData;
                            lastPendNext  = 1'b1;
                            restartNext   = FrameStart;
                            stateNext     = W_RECV;
                        end
                    end else if (holdValid) begin
                        if (full) begin
                            wrPtrNext = cmPtr;
                            dropInc   = 1'b1;
                            ovfNext   = 1'b1;
                        end else begin
                            memWe     = 1'b1;
                            memWdata  = {1'b1, holdData};
                            wrPtrNext = wrPtrInc;
                            cmPtrNext = wrPtrInc;
                            commit    = 1'b1;
                        end
                    end
                end else if (FrameStart) begin
                    wrPtrNext     = cmPtr;
                    dropInc       = 1'b1;
                    holdValidNext = 1'b0;
                end else if (RxValid) begin
                    if (!holdValid) begin
                        holdValidNext = 1'b1;
                        holdDataNext  = RxData;
                    end else if (full) begin
                        wrPtrNext     = cmPtr;
                        ovfNext       = 1'b1;
                        holdValidNext = 1'b0;
                        stateNext     = W_DROP;
                    end else begin
                        memWe        = 1'b1;
                        memWdata     = {1'b0, holdData};
                        wrPtrNext    = wrPtrInc;
                        holdDataNext = RxData;
                    end
                end
            end
            W_DROP: begin
                wrPtrNext     = cmPtr;
                holdValidNext = 1'b0;
                if (FrameEnd) begin
                    dropInc   = 1'b1;
                    stateNext = FrameStart ? W_RECV : W_IDLE;
                end else if (FrameStart) begin
                    dropInc   = 1'b1;
                    stateNext = W_RECV;
                end
            end
            default: stateNext = W_IDLE;
        endcase
    end

    always_ff @(posedge MRxClk) begin
        if (memWe) mem[wrPtr] <= memWdata;
    end

    always_ff @(posedge MRxClk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= W_IDLE;
            wrPtr     <= '0;
            cmPtr     <= '0;
            rdPtr     <= '0;
            holdValid <= 1'b0;
            holdData  <= '0;
            lastPend  <= 1'b0;
            restart   <= 1'b0;
            RdData    <= '0;
            RdValid   <= 1'b0;
            RdLast    <= 1'b0;
            FrmCnt    <= '0;
            DropCnt   <= '0;
            Overflow  <= 1'b0;
        end else begin
            state     <= stateNext;
            wrPtr     <= wrPtrNext;
            cmPtr     <= cmPtrNext;
            holdValid <= holdValidNext;
            holdData  <= holdDataNext;
            lastPend  <= lastPendNext;
            restart   <= restartNext;
            Overflow  <= ovfNext;
            if (rdLoad) begin
                RdData  <= memRd[7:0];
                RdLast  <= memRd[8];
                RdValid <= 1'b1;
                rdPtr   <= rdPtr + 1'b1;
            end else if (RdReady && RdValid) begin
                RdValid <= 1'b0;
            end
            if (commit && !frmDec)      FrmCnt <= FrmCnt + 1'b1;
            else if (!commit && frmDec) FrmCnt <= FrmCnt - 1'b1;
            if (dropInc && (DropCnt != '1)) DropCnt <= DropCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fb_slave_rx_fifo.sv
// Scoreboard bench for fb_slave_rx_fifo: stimulus queues expected bytes,
// a negedge monitor pops and compares every accepted read.
module tb_fb_slave_rx_fifo;

    logic       MRxClk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [7:0] RxData = '0;
    logic       RxValid = 1'b0;
    logic       FrameStart = 1'b0;
    logic       FrameEnd = 1'b0;
    logic       CrcError = 1'b0;
    logic [7:0] RdData;
    logic       RdValid;
    logic       RdReady = 1'b0;
    logic       RdLast;
    logic [3:0] FrmCnt;
    logic [7:0] DropCnt;
    logic       Overflow;

    int compared = 0;
    int mismatched = 0;
    int ovfSeen = 0;
    int rdValidSeen = 0;
    logic [8:0] expQ[$];

    fb_slave_rx_fifo #(.ADDR_W(4), .CNT_W(8)) dut (
        .MRxClk(MRxClk), .Reset_n(Reset_n), .RxData(RxData), .RxValid(RxValid),
        .FrameStart(FrameStart), .FrameEnd(FrameEnd), .CrcError(CrcError),
        .RdData(RdData), .RdValid(RdValid), .RdReady(RdReady), .RdLast(RdLast),
        .FrmCnt(FrmCnt), .DropCnt(DropCnt), .Overflow(Overflow)
    );

    always #5 MRxClk = ~MRxClk;

    initial begin : monitor
        logic [8:0] e;
        forever begin
            @(negedge MRxClk);
            if (Reset_n) begin
                if (Overflow) ovfSeen++;
                if (RdValid) rdValidSeen++;
                if (RdValid && RdReady) begin
                    compared++;
                    if (expQ.size() == 0) begin
                        mismatched++;
                        $display("FAIL rdUnexpected: got last=%0b data=%02h, required no byte", RdLast, RdData);
                    end else begin
                        e = expQ.pop_front();
                        if ({RdLast, RdData} !== e) begin
                            mismatched++;
                            $display("FAIL rdByte: got last=%0b data=%02h, required last=%0b data=%02h",
                                     RdLast, RdData, e[8], e[7:0]);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge MRxClk);
        #1;
    endtask

    task automatic pulseStart();
        FrameStart = 1'b1;
        cyc();
        FrameStart = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        RxValid = 1'b1;
        RxData  = b;
        cyc();
        RxValid = 1'b0;
    endtask

    task automatic endFrame(input logic crc);
        FrameEnd = 1'b1;
        CrcError = crc;
        cyc();
        FrameEnd = 1'b0;
        CrcError = 1'b0;
    endtask

    task automatic pushExp(input logic last, input logic [7:0] d);
        expQ.push_back({last, d});
    endtask

    task automatic doReset();
        Reset_n = 1'b0;
        repeat (2) cyc();
        Reset_n = 1'b1;
        expQ.delete();
        cyc();
    endtask

    task automatic waitDrain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (expQ.size() == 0 && !RdValid) begin
                done = 1'b1;
                break;
            end
            cyc();
        end
        check(name, int'(done), 1);
    endtask

    initial begin
        doReset();

        // Good 3-byte frame
        RdReady = 1'b1;
        pulseStart();
        sendByte(8'h11);
        sendByte(8'h22);
        sendByte(8'h33);
        pushExp(1'b0, 8'h11); pushExp(1'b0, 8'h22); pushExp(1'b1, 8'h33);
        endFrame(1'b0);
        check("t1FrmCntCommit", int'(FrmCnt), 1);
        check("t1RdValidBefore", int'(RdValid), 0);
        cyc();
        check("t1RdValidLatency", int'(RdValid), 1);
        check("t1FirstData", int'(RdData), 'h11);
        waitDrain("t1Drain");
        check("t1FrmCntEnd", int'(FrmCnt), 0);

        // CRC error frame, then good frame
        doReset();
        pulseStart();
        for (int i = 0; i < 4; i++) sendByte(8'(8'hE0 + i));
        endFrame(1'b1);
        check("t2DropCnt", int'(DropCnt), 1);
        check("t2NoValid", int'(RdValid), 0);
        pulseStart();
        sendByte(8'hA5);
        sendByte(8'h5A);
        pushExp(1'b0, 8'hA5); pushExp(1'b1, 8'h5A);
        endFrame(1'b0);
        waitDrain("t2Drain");
        check("t2DropCntEnd", int'(DropCnt), 1);

        // Overflow with reader stalled
        doReset();
        RdReady = 1'b0;
        ovfSeen = 0;
        rdValidSeen = 0;
        pulseStart();
        for (int i = 0; i < 20; i++) sendByte(8'(i));
        endFrame(1'b0);
        cyc();
        check("t3OvfPulses", ovfSeen, 1);
        check("t3DropCnt", int'(DropCnt), 1);
        check("t3NoRdValid", rdValidSeen, 0);
        check("t3FrmCnt", int'(FrmCnt), 0);
        pulseStart();
        sendByte(8'h01);
        sendByte(8'h02);
        sendByte(8'h03);
        pushExp(1'b0, 8'h01); pushExp(1'b0, 8'h02); pushExp(1'b1, 8'h03);
        endFrame(1'b0);
        RdReady = 1'b1;
        waitDrain("t3Drain");

        // Abort by FrameStart mid-frame
        doReset();
        pulseStart();
        sendByte(8'h44);
        sendByte(8'h55);
        pulseStart();
        sendByte(8'h7E);
        pushExp(1'b1, 8'h7E);
        endFrame(1'b0);
        check("t4DropCnt", int'(DropCnt), 1);
        waitDrain("t4Drain");

        // Last byte coincident with FrameEnd
        doReset();
        pulseStart();
        sendByte(8'h98);
        pushExp(1'b0, 8'h98); pushExp(1'b1, 8'h99);
        RxValid = 1'b1;
        RxData  = 8'h99;
        endFrame(1'b0);
        RxValid = 1'b0;
        check("t5FrmCntStaged", int'(FrmCnt), 0);
        cyc();
        check("t5FrmCntCommit", int'(FrmCnt), 1);
        check("t5NoValidYet", int'(RdValid), 0);
        waitDrain("t5Drain");

        // Commit coincides with pop of previous frame's last byte
        doReset();
        RdReady = 1'b0;
        pulseStart();
        sendByte(8'hC1);
        sendByte(8'hC2);
        pushExp(1'b0, 8'hC1); pushExp(1'b1, 8'hC2);
        endFrame(1'b0);
        pulseStart();
        RdReady = 1'b1;
        sendByte(8'hD1);
        pushExp(1'b1, 8'hD1);
        check("t6FrmCntBefore", int'(FrmCnt), 1);
        check("t6LastPresented", int'(RdLast), 1);
        endFrame(1'b0);
        check("t6FrmCntSame", int'(FrmCnt), 1);
        waitDrain("t6Drain");
        check("t6FrmCntEnd", int'(FrmCnt), 0);

        // Reset mid-read
        pulseStart();
        sendByte(8'hBB);
        endFrame(1'b1);
        pulseStart();
        sendByte(8'hC0);
        sendByte(8'hC3);
        sendByte(8'hC6);
        pushExp(1'b0, 8'hC0); pushExp(1'b0, 8'hC3); pushExp(1'b1, 8'hC6);
        endFrame(1'b0);
        cyc();
        check("t7RdValidPre", int'(RdValid), 1);
        check("t7DropCntPre", int'(DropCnt), 1);
        #1;
        Reset_n = 1'b0;
        #1;
        check("t7RstRdValid", int'(RdValid), 0);
        check("t7RstRdData", int'(RdData), 0);
        check("t7RstRdLast", int'(RdLast), 0);
        check("t7RstFrmCnt", int'(FrmCnt), 0);
        check("t7RstDropCnt", int'(DropCnt), 0);
        check("t7RstOverflow", int'(Overflow), 0);
        expQ.delete();
        cyc();
        Reset_n = 1'b1;
        cyc();
        pulseStart();
        sendByte(8'h3C);
        pushExp(1'b1, 8'h3C);
        endFrame(1'b0);
        waitDrain("t7Recover");

        check("queueEmpty", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
